max_seq_ctrl: RTL and testbench
===============================

MAX_SEQ_CTRL -- requirements
Module: max_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 3, operand width in bits (unsigned).
REQ-002 Parameter CNT_W, default 4, beat-index width; nominal max frame length 2^CNT_W.
REQ-003 Port clk input 1: single clock; all state updates on rising edge.
REQ-004 Port rst input 1: reset, synchronous, active-high.
REQ-005 Port in_valid input 1: operand beat offered.
REQ-006 Port in_ready output 1: block can accept a beat.
REQ-007 Port in_data input WIDTH: operand.
REQ-008 Port in_last input 1: beat is the final beat of its frame.
REQ-009 Port out_valid output 1: frame result available.
REQ-010 Port out_ready input 1: consumer takes the result.
REQ-011 Port out_max output WIDTH: maximum operand of the frame.
REQ-012 Port out_ovf output 1: frame exceeded 2^CNT_W beats.
REQ-013 Port out_idx output CNT_W: zero-based index of the winning beat; present only with MAX_SEQ_IDX_EN.

Function
REQ-014 The block SHALL implement FSM states IDLE, ACCUM and HOLD.
REQ-015 A beat SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-017 A beat accepted in IDLE SHALL load max <= in_data, idx <= 0, cnt <= 1, ovf <= 0; next state is HOLD if in_last, else ACCUM.
REQ-018 A beat accepted in ACCUM SHALL replace max and set idx <= cnt only if in_data > max (strict unsigned); ties keep the earlier beat.
REQ-019 In ACCUM, cnt SHALL increment per accepted beat and saturate at 2^CNT_W - 1; ovf SHALL set (sticky for the frame) when a beat is accepted while cnt = 2^CNT_W - 1 and the previous beat filled the last index.
REQ-020 A winning beat accepted after saturation SHALL record idx = all-ones.
REQ-021 Acceptance of a beat with in_last in ACCUM SHALL move the FSM to HOLD.
REQ-022 out_valid SHALL be 1 exactly while in HOLD; first assertion is the cycle after the in_last beat is accepted (1-cycle latency).
REQ-023 out_max, out_ovf and out_idx SHALL be registered and stable throughout HOLD.
REQ-024 In HOLD, out_valid and out_ready both 1 SHALL return the FSM to IDLE next cycle; no beat is accepted in that cycle.
REQ-025 in_valid low SHALL stall the FSM in its current state with no state change.
REQ-026 Outputs outside HOLD SHALL be don't-care to the consumer but SHALL NOT be X.

Reset
REQ-027 rst high SHALL force IDLE, in_ready 1, out_valid 0, out_max 0, out_ovf 0, out_idx 0, cnt 0 on the next edge.
REQ-028 rst asserted mid-frame or in HOLD SHALL discard the partial frame or pending result without emitting it.

Configuration
REQ-029 Macro MAX_SEQ_IDX_EN defined: idx register and out_idx port SHALL be present with behaviour as above.
REQ-030 MAX_SEQ_IDX_EN undefined: out_idx port and idx register SHALL be absent; all other behaviour unchanged.

Verification (WIDTH=3, CNT_W=4, MAX_SEQ_IDX_EN defined)
REQ-031 Frame 3,5,2(last), back-to-back -> out_valid one cycle after beat 2 accepted, out_max=5, out_idx=1, out_ovf=0.
REQ-032 Frame 6,6,6(last) -> out_max=6, out_idx=0 (tie keeps first).
REQ-033 Single beat 7 with in_last in IDLE -> next cycle HOLD, out_max=7, out_idx=0, in_ready=0.
REQ-034 Result pending, out_ready held 0 for 5 cycles while in_valid=1 -> out_valid stays 1, in_ready stays 0, outputs unchanged; out_ready=1 -> IDLE next cycle, then next frame accepted.
REQ-035 17-beat frame, all 1 except beat 16 = 4 (last) -> out_ovf=1, out_max=4, out_idx=15.
REQ-036 rst pulsed after 2 beats of a frame -> out_valid never asserts for it; following frame 1(last) -> out_max=1, out_idx=0.

Source files
------------

// File: rtl/max_seq_ctrl.sv
// -----------------------------------------------------------------------------
// max_seq_ctrl
//
// Purpose:
//   Streams a frame of unsigned operands in over a valid/ready handshake and
//   reports the largest operand of the frame once the last beat is taken.
//   The result is held until the consumer accepts it. No new beat is taken
//   while a result is pending. Frames longer than 2^CNT_W beats are flagged
//   with a sticky overflow bit.
//
// Build option:
//   MAX_SEQ_IDX_EN - when defined, the block also tracks the zero-based
//                    index of the winning beat and drives it on out_idx.
//                    When undefined, the index register and the out_idx
//                    port do not exist.
//
// Parameters:
//   WIDTH  - operand width in bits (unsigned)
//   CNT_W  - beat-index width; nominal maximum frame length is 2^CNT_W
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous, active-high reset
//   in_valid   in   operand beat offered
//   in_ready   out  block can accept a beat (IDLE or ACCUM)
//   in_data    in   operand
//   in_last    in   beat is the final beat of its frame
//   out_valid  out  frame result available (exactly while in HOLD)
//   out_ready  in   consumer takes the result
//   out_max    out  maximum operand of the frame
//   out_ovf    out  frame exceeded 2^CNT_W beats
//   out_idx    out  index of the winning beat (MAX_SEQ_IDX_EN only)
// -----------------------------------------------------------------------------
module max_seq_ctrl #(
   parameter int WIDTH = 3,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic             out_ovf
`ifdef MAX_SEQ_IDX_EN
   ,
   output logic [CNT_W-1:0] out_idx
`endif
);

   // FSM encoding
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   // Saturation value of the beat counter, also the all-ones index.
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] max_q,   max_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             ovf_q,   ovf_d;
   // Set once a beat has occupied index CNT_MAX; the next accepted beat of
   // the same frame is then beyond 2^CNT_W and raises the overflow flag.
   logic             full_q,  full_d;
`ifdef MAX_SEQ_IDX_EN
   logic [CNT_W-1:0] idx_q,   idx_d;
`endif

   logic accept;
   logic take_result;

   // in_ready is decoded from legal accepting states only, so an illegal
   // encoding never swallows a beat before it is steered back to IDLE.
   assign in_ready    = (state_q == S_IDLE) || (state_q == S_ACCUM);
   assign out_valid   = (state_q == S_HOLD);
   assign accept      = in_valid && in_ready;
   assign take_result = out_valid && out_ready;

   // ---------------------------------------------------------------------------
   // Next-state and datapath update
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      state_d = state_q;
      max_d   = max_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      full_d  = full_q;
`ifdef MAX_SEQ_IDX_EN
      idx_d   = idx_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               // First beat of a frame seeds the running maximum.
               max_d  = in_data;
               cnt_d  = CNT_W'(1);
               ovf_d  = 1'b0;
               full_d = 1'b0;
`ifdef MAX_SEQ_IDX_EN
               idx_d  = '0;
`endif
               state_d = in_last ? S_HOLD : S_ACCUM;
            end
         end

         S_ACCUM: begin
            if (accept) begin
               // Strict compare: on a tie the earlier beat keeps the win.
               if (in_data > max_q) begin
                  max_d = in_data;
`ifdef MAX_SEQ_IDX_EN
                  // cnt_q is this beat's index, or all-ones once saturated.
                  idx_d = cnt_q;
`endif
               end

               if (cnt_q == CNT_MAX) begin
                  // Counter is saturated: the first beat here fills the last
                  // index, any further beat overflows the frame.
                  if (full_q) begin
                     ovf_d = 1'b1;
                  end else begin
                     full_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end

               if (in_last) begin
                  state_d = S_HOLD;
               end
            end
         end

         S_HOLD: begin
            // Result registers are frozen here; only the handshake leaves.
            if (take_result) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: the datapath registers are reset along with the FSM so the result
   // outputs are defined (never X) even before the first frame completes.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (rst) begin
         state_q <= S_IDLE;
         max_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         full_q  <= 1'b0;
`ifdef MAX_SEQ_IDX_EN
         idx_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         max_q   <= max_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         full_q  <= full_d;
`ifdef MAX_SEQ_IDX_EN
         idx_q   <= idx_d;
`endif
      end
   end

   // Result outputs come straight from registers, so they stay stable for
   // the whole HOLD period.
   assign out_max = max_q;
   assign out_ovf = ovf_q;
`ifdef MAX_SEQ_IDX_EN
   assign out_idx = idx_q;
`endif

endmodule

// File: tb/tb_max_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_max_seq_ctrl
//
// Directed-vector bench for max_seq_ctrl (WIDTH=3, CNT_W=4). The stimulus
// process pushes the hand-computed result of each frame into a queue as its
// last beat is offered; an independent monitor pops and compares whenever
// out_valid rises and checks the result stays frozen while it is held.
// Index checks are active when MAX_SEQ_IDX_EN is defined.
// -----------------------------------------------------------------------------
module tb_max_seq_ctrl;

   localparam int WIDTH = 3;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_max;
   logic             out_ovf;
`ifdef MAX_SEQ_IDX_EN
   logic [CNT_W-1:0] out_idx;
`endif

   max_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_max   (out_max),
      .out_ovf   (out_ovf)
`ifdef MAX_SEQ_IDX_EN
      ,
      .out_idx   (out_idx)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [WIDTH-1:0] max;
      logic             ovf;
      logic [CNT_W-1:0] idx;
      int               cyc;
   } exp_t;

   exp_t exp_q[$];

   int n_cmp  = 0;
   int n_fail = 0;

   // Expected result for the frame currently being sent.
   logic [WIDTH-1:0] p_max;
   logic [CNT_W-1:0] p_idx;
   logic             p_ovf;

   task automatic check(input string name, input int unsigned act, input int unsigned req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic expect_result(input int m, input int idx, input int ovf);
      p_max = m[WIDTH-1:0];
      p_idx = idx[CNT_W-1:0];
      p_ovf = ovf[0];
   endtask

   // Called at a negedge; offers one beat and returns at the negedge after
   // the edge that accepted it.
   task automatic beat(input int d, input bit last);
      int   guard = 0;
      exp_t e;
      in_valid = 1'b1;
      in_data  = d[WIDTH-1:0];
      in_last  = last;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         check("beat_accept_timeout", 0, 1);
      end else if (last) begin
         e.max = p_max;
         e.ovf = p_ovf;
         e.idx = p_idx;
         e.cyc = cyc + 1;
         exp_q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
      repeat (n) @(negedge clk);
   endtask

   // ---------------------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------------------
   logic prev_v = 1'b0;
   exp_t cur;

   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            prev_v = 1'b0;
         end else begin
            if (out_valid && !prev_v) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_result", 1, 0);
               end else begin
                  cur = exp_q.pop_front();
                  check("out_max", out_max, cur.max);
                  check("out_ovf", out_ovf, cur.ovf);
`ifdef MAX_SEQ_IDX_EN
                  check("out_idx", out_idx, cur.idx);
`endif
                  check("result_cycle", cyc, cur.cyc);
               end
            end else if (out_valid && prev_v) begin
               check("hold_max", out_max, cur.max);
               check("hold_ovf", out_ovf, cur.ovf);
`ifdef MAX_SEQ_IDX_EN
               check("hold_idx", out_idx, cur.idx);
`endif
            end
            if (out_valid) check("in_ready_in_hold", in_ready, 0);
            prev_v = out_valid;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("rst_in_ready",  in_ready,  1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_max",   out_max,   0);
      check("rst_out_ovf",   out_ovf,   0);
`ifdef MAX_SEQ_IDX_EN
      check("rst_out_idx",   out_idx,   0);
`endif

      // 3,5,2(last) back-to-back, then 6,6,6(last) back-to-back
      expect_result(5, 1, 0);
      beat(3, 0); beat(5, 0); beat(2, 1);
      expect_result(6, 0, 0);
      beat(6, 0); beat(6, 0); beat(6, 1);
      idle(2);

      // Single-beat frame: HOLD on the next cycle with in_ready low
      expect_result(7, 0, 0);
      beat(7, 1);
      check("single_out_valid", out_valid, 1);
      check("single_in_ready",  in_ready,  0);
      idle(2);

      // Stalls between beats; later tie does not steal the win
      expect_result(5, 1, 0);
      beat(2, 0); idle(3); beat(5, 0); idle(1); beat(5, 0); beat(1, 1);
      idle(2);

      // Consumer back-pressure for 5 cycles with a beat offered throughout
      out_ready = 1'b0;
      expect_result(3, 1, 0);
      beat(2, 0); beat(3, 1);
      in_valid = 1'b1; in_data = 3'd7; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready",  in_ready,  0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("release_out_valid", out_valid, 0);
      check("release_in_ready",  in_ready,  1);
      idle(0);
      expect_result(4, 0, 0);
      beat(4, 0); beat(1, 1);
      idle(2);

      // Exactly 16 beats: last index filled, no overflow
      expect_result(5, 15, 0);
      for (int i = 0; i < 15; i++) beat(2, 0);
      beat(5, 1);
      idle(2);

      // 17 beats: overflow, winner after saturation records all-ones index
      expect_result(4, 15, 1);
      for (int i = 0; i < 16; i++) beat(1, 0);
      beat(4, 1);
      idle(2);

      // Reset mid-frame discards the partial frame
      beat(6, 0); beat(5, 0);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_in_ready",  in_ready,  1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_max",   out_max,   0);
      idle(3);
      expect_result(1, 0, 0);
      beat(1, 1);
      idle(2);

      // Reset while a result is held drops it
      out_ready = 1'b0;
      expect_result(3, 0, 0);
      beat(3, 1);
      check("hold_before_rst", out_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      check("holdrst_out_valid", out_valid, 0);
      check("holdrst_out_max",   out_max,   0);
      idle(3);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
